// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, debounce
// state encoding and a population-count helper.
package keypad_pkg;

   localparam int unsigned NUM_ROWS = 4;
   localparam int unsigned NUM_COLS = 4;
   localparam int unsigned KEY_W    = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      ACCEPT
   } deb_state_t;

   function automatic logic [4:0] popcount16(input logic [KEY_W-1:0] v);
      logic [4:0] n;
      n = '0;
      for (int unsigned i = 0; i < KEY_W; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// One-hot key interface: the scanner drives it (master); the downstream
// encoder reads it (slave).
interface keypad_scan_if;
   import keypad_pkg::*;

   logic [KEY_W-1:0] onehot;
   logic             key_valid;
   logic             key_pulse;

   modport master (output onehot, key_valid, key_pulse);
   modport slave  (input  onehot, key_valid, key_pulse);

endinterface

// File: rtl/keypad_debounce.sv
// Debounces full-matrix snapshots: a snapshot is accepted after DEBOUNCE_SCANS
// identical consecutive snapshots, then filtered to single-key presses.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int unsigned DEBOUNCE_SCANS = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [KEY_W-1:0] snap,
   input  logic             snap_done,
   keypad_scan_if.master    key
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

   deb_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [KEY_W-1:0] prev;
   logic [KEY_W-1:0] onehot_q, onehot_nx;
   logic             valid_q, pulse_q, pulse_nx;
   logic             match;

   assign match = (snap == prev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (snap_done) begin
               if (match) begin
                  cnt_nx   = CNT_W'(1);
                  state_nx = (cnt_nx == CNT_LAST) ? ACCEPT : COUNT;
               end else begin
                  cnt_nx = '0;
               end
            end
         end
         COUNT: begin
            if (snap_done) begin
               if (match) begin
                  cnt_nx = cnt + 1'b1;
                  if (cnt_nx == CNT_LAST) state_nx = ACCEPT;
               end else begin
                  cnt_nx   = '0;
                  state_nx = IDLE;
               end
            end
         end
         ACCEPT: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
         default: begin
            cnt_nx   = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // prev holds the accepted snapshot during ACCEPT, independent of raw capture timing
   always_comb begin
      onehot_nx = onehot_q;
      pulse_nx  = 1'b0;
      if (state == ACCEPT) begin
         if (popcount16(prev) == 5'd1) begin
            onehot_nx = prev;
            pulse_nx  = (prev != onehot_q);
         end else if (popcount16(prev) == 5'd0) begin
            onehot_nx = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         prev     <= '0;
         onehot_q <= '0;
         valid_q  <= 1'b0;
         pulse_q  <= 1'b0;
      end else begin
         cnt      <= cnt_nx;
         if (snap_done) prev <= snap;
         onehot_q <= onehot_nx;
         valid_q  <= |onehot_nx;
         pulse_q  <= pulse_nx;
      end
   end

   assign key.onehot    = onehot_q;
   assign key.key_valid = valid_q;
   assign key.key_pulse = pulse_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: active-low column strobe, two-flop row
// synchroniser, raw snapshot capture, and debounce into a one-hot key vector.
module keypad_scan
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 4,
   parameter int unsigned DEBOUNCE_SCANS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_out,
   keypad_scan_if.master       key
);

   localparam int unsigned     DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [NUM_ROWS-1:0] sync1, sync2, rows_s;
   logic [DIV_W-1:0]    div;
   logic [1:0]          col;
   logic [KEY_W-1:0]    raw;
   logic                snap_done;

   assign rows_s = ~sync2;

   // Strobe for the next column is launched on the same edge that samples this one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1     <= '1;
         sync2     <= '1;
         div       <= '0;
         col       <= '0;
         col_out   <= 4'b1110;
         raw       <= '0;
         snap_done <= 1'b0;
      end else begin
         sync1     <= row_in;
         sync2     <= sync1;
         snap_done <= 1'b0;
         if (div == DIV_LAST) begin
            div                          <= '0;
            raw[col*NUM_ROWS +: NUM_ROWS] <= rows_s;
            col                          <= col + 1'b1;
            col_out                      <= ~(NUM_COLS'(1) << (col + 1'b1));
            snap_done                    <= (col == 2'(NUM_COLS - 1));
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .snap      (raw),
      .snap_done (snap_done),
      .key       (key)
   );

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: snapshot-level key patterns drive a
// behavioural debounce model; a monitor checks strobe sequence and key events.
module tb_keypad_scan;
   import keypad_pkg::*;

   localparam int unsigned SCAN_DIV       = 4;
   localparam int unsigned DEBOUNCE_SCANS = 3;
   localparam int unsigned SNAP_CLKS      = 4 * SCAN_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [15:0] mask = '0;

   keypad_scan_if key ();

   keypad_scan #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .row_in  (row_in),
      .col_out (col_out),
      .key     (key)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low while its column is strobed
   always_comb begin
      row_in = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (col_out[c] == 1'b0) begin
            for (int r = 0; r < 4; r++) begin
               if (mask[c*4 + r]) row_in[r] = 1'b0;
            end
         end
      end
   end

   typedef struct {
      logic [15:0] oh;
      logic        valid;
      logic        pulse;
      int unsigned at;
   } ev_t;

   ev_t         exp_q[$];
   int unsigned cyc = 0;
   int unsigned rel = 0;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [15:0] m_last = '0;
   logic [15:0] m_oh   = '0;
   int unsigned m_run  = 1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_reset();
      m_last = '0;
      m_oh   = '0;
      m_run  = 1;
   endtask

   // Accept after DEBOUNCE_SCANS identical snapshots in a row; the accepted
   // snapshot then starts the next run.
   task automatic model_snapshot(input logic [15:0] s, input int unsigned end_cyc);
      ev_t e;
      if (s == m_last) m_run++;
      else             m_run = 1;
      m_last = s;
      if (m_run == DEBOUNCE_SCANS) begin
         m_run = 1;
         if ($countones(s) == 1 && s != m_oh) begin
            m_oh = s;
            e = '{oh: s, valid: 1'b1, pulse: 1'b1, at: end_cyc + 2};
            exp_q.push_back(e);
         end else if (s == 16'h0000 && m_oh != 16'h0000) begin
            m_oh = '0;
            e = '{oh: 16'h0000, valid: 1'b0, pulse: 1'b0, at: end_cyc + 2};
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic run_snap(input logic [15:0] m);
      mask = m;
      repeat (SNAP_CLKS) @(negedge clk);
      model_snapshot(m, cyc);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got %h want %h at cyc %0d", name, got, want, cyc);
      end
   endtask

   logic [15:0] last_oh    = '0;
   logic        last_valid = 1'b0;

   always @(posedge clk) begin
      ev_t         e;
      logic [3:0]  exp_col;
      int unsigned k;
      #2;
      if (rst) begin
         last_oh    = key.onehot;
         last_valid = key.key_valid;
      end else begin
         k       = cyc - rel;
         exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
         check("col_out", 32'(col_out), 32'(exp_col));
         if (key.key_pulse || key.onehot !== last_oh || key.key_valid !== last_valid) begin
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_event onehot=%h valid=%b pulse=%b at cyc %0d",
                        key.onehot, key.key_valid, key.key_pulse, cyc);
            end else begin
               e = exp_q.pop_front();
               check("event_onehot", 32'(key.onehot), 32'(e.oh));
               check("event_valid", 32'(key.key_valid), 32'(e.valid));
               check("event_pulse", 32'(key.key_pulse), 32'(e.pulse));
               check("event_cycle", 32'(cyc), 32'(e.at));
            end
         end else if (exp_q.size() != 0 && cyc >= exp_q[0].at) begin
            e = exp_q.pop_front();
            miscompares++;
            $display("FAIL missing_event got onehot=%h want onehot=%h pulse=%b at cyc %0d",
                     key.onehot, e.oh, e.pulse, cyc);
         end
         last_oh    = key.onehot;
         last_valid = key.key_valid;
      end
   end

   initial begin
      logic [15:0] one;
      logic [15:0] m;
      int unsigned r;
      one = 16'h0001;

      repeat (3) @(negedge clk);
      check("reset_col_out", 32'(col_out), 32'h0000_000E);
      check("reset_onehot", 32'(key.onehot), 32'h0);
      check("reset_valid", 32'(key.key_valid), 32'h0);
      check("reset_pulse", 32'(key.key_pulse), 32'h0);
      model_reset();
      rst = 1'b0;
      rel = cyc;

      // idle, single held key, release
      repeat (6) run_snap(16'h0000);
      repeat (4) run_snap(16'h0200);
      repeat (4) run_snap(16'h0000);

      // bounce on the same key, then settle
      for (int i = 0; i < 12; i++) run_snap(($urandom_range(0, 1) == 1) ? 16'h0200 : 16'h0000);
      repeat (4) run_snap(16'h0200);

      // two keys held: ignored until one is released
      repeat (4) run_snap(16'h0020);
      repeat (4) run_snap(16'h1020);
      repeat (4) run_snap(16'h1000);

      // direct change without release, then release all
      repeat (4) run_snap(16'h0004);
      repeat (4) run_snap(16'h0000);

      // randomized key activity
      m = '0;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r >= 6 && r < 8)  m = one << $urandom_range(0, 15);
         else if (r == 8)      m = '0;
         else if (r == 9)      m = (one << $urandom_range(0, 15)) | (one << $urandom_range(0, 15));
         run_snap(m);
      end
      repeat (4) run_snap(16'h0000);

      // reset mid-snapshot with a key held
      repeat (4) run_snap(16'h0008);
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset_col_out", 32'(col_out), 32'h0000_000E);
      check("midreset_onehot", 32'(key.onehot), 32'h0);
      check("midreset_valid", 32'(key.key_valid), 32'h0);
      check("midreset_pulse", 32'(key.key_pulse), 32'h0);
      check("midreset_pending", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      repeat (4) run_snap(16'h0008);
      repeat (4) run_snap(16'h0000);

      repeat (4) @(negedge clk);
      check("drain_pending", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Drives a 4x4 matrix keypad: walks an active-low column strobe, synchronises and samples the row lines, and debounces full-matrix snapshots.
- Presents the result as a 16-bit one-hot key vector plus a press pulse.
- It is the producer end of the one-hot key interface; the downstream one-hot-to-binary encoder consumes onehot directly.

Parameters:
- SCAN_DIV, 4, clocks each column is driven before its rows are sampled; legal values are 4 and above.
- DEBOUNCE_SCANS, 3, number of consecutive identical full-matrix snapshots needed to accept a new key state; legal values are 2 and above.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- row_in  input  4  keypad rows; active-low, external pull-ups; asynchronous to clk
- col_out  output  4  column strobe; active-low, exactly one bit low at any time
- onehot  output  16  debounced key vector; bit index = col*4 + row; zero means no key
- key_valid  output  1  high while onehot is nonzero
- key_pulse  output  1  one-cycle pulse when onehot takes a new nonzero value

Behaviour:
- Reset (async assert, sync release):
  - col_out=4'b1110, onehot=16'h0000, key_valid=0, key_pulse=0.
  - Internal state cleared: divider, column index, raw snapshot, previous snapshot, stable count, row synchroniser (to 4'b1111).
- Row synchroniser: two flops on row_in; rows_s = inverted output of the second flop (1 = pressed).
- Scan counter:
  - div counts 0..SCAN_DIV-1, then wraps.
  - On div==SCAN_DIV-1: raw[col*4 +: 4] <= rows_s; col advances 0->1->2->3->0 (wraps).
  - col_out = ~(4'b0001 << col), registered. The new column strobe appears on the same edge that samples the old column.
  - A full snapshot takes 4*SCAN_DIV clocks.
- Snapshot complete: the edge that samples col 3. One cycle later, snap_done pulses and the debounce FSM evaluates snap = raw.
- Debounce FSM, states IDLE, COUNT, ACCEPT:
  - IDLE: on snap_done, if snap==prev, go to COUNT with cnt=1. Otherwise cnt=0 and stay. prev <= snap in every case.
  - COUNT: on snap_done, if snap==prev, cnt++. When cnt reaches DEBOUNCE_SCANS-1, go to ACCEPT. If snap!=prev, return to IDLE with cnt=0. prev <= snap.
  - ACCEPT: lasts exactly one cycle, then returns to IDLE with cnt=0.
  - Result: a snapshot is accepted after DEBOUNCE_SCANS identical consecutive snapshots.
- Accept rules, applied on the ACCEPT cycle with registered update:
  - popcount(snap)==1: onehot <= snap. If snap differs from the current onehot, key_pulse=1 on that same edge.
  - popcount(snap)==0: onehot <= 0; no pulse.
  - popcount(snap)>=2 (multi-key or ghosting): onehot holds its value; no pulse.
  - Accepting a snapshot equal to the current onehot causes no change and no pulse (held key: one pulse only).
- key_valid = |onehot, registered alongside onehot.
- Latency: from the first sample of a stable state to the onehot update is (DEBOUNCE_SCANS-1)*4*SCAN_DIV + 2 clocks after the snapshot containing it completes.
- Bounce: any snapshot mismatch restarts the count; onehot is unchanged until a run is stable.
- Reset mid-scan or mid-debounce: everything returns to reset values immediately. After release, scanning restarts at col 0; no pulse is generated by reset.
- Direct key change A->B without a release snapshot: accepted as a new press; onehot=B, one pulse.

Decomposition:
- Shared package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=4, KEY_W=16.
  - Debounce state enum {IDLE, COUNT, ACCEPT}.
  - Function popcount16 (or is_onehot16).
- One sub-module, keypad_debounce: snap/snap_done in, onehot/key_valid/key_pulse out; contains the FSM, prev and cnt.
- keypad_scan keeps the synchroniser, divider, column strobe and raw capture.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, one snapshot = 16 clocks):
- Idle scan, rows all 1 -> col_out cycles 1110, 1101, 1011, 0111, each held 4 clocks; onehot stays 16'h0000; key_valid=0; key_pulse never asserts.
- Hold key col2/row1 (row_in[1]=0 only while col_out=1011) for 4 full snapshots -> onehot=16'h0200, key_valid=1; exactly one key_pulse, on the 3rd identical snapshot's ACCEPT; no further pulses while held.
- Bounce: toggle the same key every 20 clocks for 200 clocks, then hold -> onehot stays 0 during bounce; 16'h0200 with one pulse only after 3 stable snapshots.
- Hold col1/row1 (16'h0020), then add col3/row0 (16'h1000) -> onehot stays 16'h0020, no pulse. Release col1/row1 -> onehot=16'h1000 after debounce, one pulse.
- Release all keys -> onehot=0, key_valid=0 after 3 stable snapshots; no pulse.
- Assert rst for 1 clock mid-snapshot with a key held -> immediately col_out=1110, onehot=0, key_pulse=0. Key re-accepted 3 snapshots later with one pulse.
